// File: rtl/demux_pkg.sv
// Shared constants and bus-slicing helpers for the 1-to-4 buffered stream demux.
// Channel i of every packed per-channel bus lives at [i*W +: W].
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // LSB position of channel ch in a packed bus of w-bit fields
  function automatic int slice_lsb(input int ch, input int w);
    return ch * w;
  endfunction

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry holding register, full bit and delivered-beat counter.
// Latency 1 cycle from load; a full slot draining this cycle may be refilled in the same cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              can_take_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              drain;

  assign drain      = valid_q & ready_i;
  assign can_take_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = load_i | (valid_q & ~ready_i);
    data_d  = load_i ? data_i : data_q;
    // Counts the drained beat even when the slot is reloaded in the same cycle
    cnt_d   = cnt_q + CNT_W'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 stream demux with broadcast; 1-cycle latency, one beat/cycle/channel.
// in_ready is combinational from slot occupancy; broadcasts wait until all four slots can take.
module demux1to4_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]  out_cnt
);

  logic [NUM_CH-1:0] can_take;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] load;
  logic              accept;

  assign sel_oh = sel_onehot(in_sel);
  assign target = in_bcast ? {NUM_CH{1'b1}} : sel_oh;

  // Broadcast needs every slot free so that it loads all four or none
  assign in_ready = in_bcast ? (&can_take) : (|(can_take & sel_oh));
  assign accept   = in_valid & in_ready;
  assign load     = accept ? target : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    localparam int DLSB = slice_lsb(g, DATA_W);
    localparam int CLSB = slice_lsb(g, CNT_W);

    demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[g]),
      .data_i     (in_data),
      .ready_i    (out_ready[g]),
      .valid_o    (out_valid[g]),
      .data_o     (out_data[DLSB +: DATA_W]),
      .cnt_o      (out_cnt[CLSB +: CNT_W]),
      .can_take_o (can_take[g])
    );
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed stimulus with a per-channel scoreboard; a negedge monitor pops and compares
// every output handshake, while the stimulus side checks in_ready, occupancy and counters.
module tb_demux1to4_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [3:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q [4][$];
  logic [3:0] prev_data [4];
  logic [3:0] prev_hold;
  bit         watch_ch3 = 1'b0;

  always #5 clk = ~clk;

  demux1to4_buf #(.DATA_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; presents one beat for one cycle and records it if it should be accepted
  task automatic send(input logic [1:0] sel, input logic bc, input logic [3:0] d,
                      input logic exp_rdy, input string name);
    in_valid = 1'b1;
    in_sel   = sel;
    in_bcast = bc;
    in_data  = d;
    @(negedge clk);
    chk(name, {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      for (int i = 0; i < 4; i++)
        if (bc || sel == i[1:0]) exp_q[i].push_back(d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every output handshake must match the oldest expected beat of that channel
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (prev_hold[i] && out_valid[i])
          chk($sformatf("stable_ch%0d", i), {28'd0, out_data[i*4 +: 4]}, {28'd0, prev_data[i]});
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_beat_ch%0d", i), {28'd0, out_data[i*4 +: 4]}, 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("data_ch%0d", i), {28'd0, out_data[i*4 +: 4]}, {28'd0, exp_q[i].pop_front()});
          end
        end
        prev_hold[i] = out_valid[i] & ~out_ready[i];
        prev_data[i] = out_data[i*4 +: 4];
      end
      if (watch_ch3) chk("ch3_continuous", {31'd0, out_valid[3]}, 32'd1);
    end else begin
      prev_hold = '0;
    end
  end

  initial begin
    prev_hold = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    in_data   = 4'h0;
    out_ready = 4'b0000;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_out_data",  {16'd0, out_data}, 32'h0);
    chk("rst_out_cnt",   out_cnt, 32'h0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // First beat: exactly one cycle of latency
    send(2'd2, 1'b0, 4'hA, 1'b1, "t1_ready");
    chk("t1_valid", {28'd0, out_valid}, 32'h4);
    chk("t1_data",  {28'd0, out_data[11:8]}, 32'hA);
    out_ready = 4'b1111;
    idle(2);

    // Back-to-back streaming into channel 1
    for (int d = 1; d <= 10; d++) send(2'd1, 1'b0, 4'(d), 1'b1, "t2_ready");
    idle(2);
    chk("t2_cnt_ch1", {24'd0, out_cnt[15:8]}, 32'd10);
    chk("t2_cnt_ch2", {24'd0, out_cnt[23:16]}, 32'd1);

    // Stall isolation: ch0 stuck, ch3 keeps flowing
    out_ready = 4'b1110;
    send(2'd0, 1'b0, 4'h7, 1'b1, "t3_first");
    send(2'd0, 1'b0, 4'h8, 1'b0, "t3_blocked");
    send(2'd3, 1'b0, 4'h5, 1'b1, "t3_other");
    chk("t3_ch0_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("t3_ch0_data",  {28'd0, out_data[3:0]}, 32'h7);
    out_ready = 4'b1111;
    idle(2);

    // Atomic broadcast
    out_ready = 4'b1011;
    send(2'd2, 1'b0, 4'h9, 1'b1, "t4_fill_ch2");
    send(2'd0, 1'b1, 4'hC, 1'b0, "t4_bcast_blocked");
    chk("t4_no_partial", {28'd0, out_valid}, 32'h4);
    chk("t4_ch2_held",   {28'd0, out_data[11:8]}, 32'h9);
    out_ready = 4'b0000;
    @(negedge clk);
    out_ready = 4'b1111;
    @(posedge clk); #1;
    send(2'd0, 1'b1, 4'hC, 1'b1, "t4_bcast_ok");
    chk("t4_all_valid", {28'd0, out_valid}, 32'hF);
    chk("t4_all_data",  {16'd0, out_data}, 32'hCCCC);
    idle(2);

    // Counter wrap on ch3 (2 prior beats), continuous drain+load
    chk("t5_cnt_before", {24'd0, out_cnt[31:24]}, 32'd2);
    for (int j = 0; j < 256; j++) begin
      send(2'd3, 1'b0, 4'(j), 1'b1, "t5_ready");
      if (j == 0) watch_ch3 = 1'b1;
      if (j == 254) chk("t5_cnt_wrap0", {24'd0, out_cnt[31:24]}, 32'd0);
    end
    watch_ch3 = 1'b0;
    idle(2);
    chk("t5_cnt_after", {24'd0, out_cnt[31:24]}, 32'd2);

    // Mid-operation asynchronous reset
    out_ready = 4'b0000;
    send(2'd0, 1'b0, 4'h3, 1'b1, "t6_fill0");
    send(2'd2, 1'b0, 4'h4, 1'b1, "t6_fill2");
    chk("t6_full", {28'd0, out_valid}, 32'h5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    #1;
    chk("t6_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("t6_rst_cnt",   out_cnt, 32'h0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    idle(4);
    chk("t6_no_stale", {28'd0, out_valid}, 32'h0);
    chk("t6_cnt_still0", out_cnt, 32'h0);

    for (int i = 0; i < 4; i++)
      chk($sformatf("final_queue_ch%0d", i), exp_q[i].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- Registered 1-to-4 stream demultiplexer: one valid/ready input stream is steered by a 2-bit select to one of four output channels, or broadcast to all four.
- Each output channel has a one-entry holding register, so the input and output handshakes are decoupled by one cycle.
- It is the distribution counterpart of the team's 4-to-1 selection muxes and feeds four independent 4-bit consumers.
- Each channel keeps a wrap-around count of delivered beats for debug.

Parameters:
- DATA_W, 4, width of every data path.
- CNT_W, 8, width of each per-channel delivered-beat counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the input beat this cycle (combinational).
- in_sel  input  2  destination channel 0..3; ignored when in_bcast=1.
- in_bcast  input  1  deliver the beat to all four channels.
- in_data  input  DATA_W  input payload.
- out_valid  output  4  bit i: channel i holds a beat.
- out_ready  input  4  bit i: consumer i accepts this cycle.
- out_data  output  4*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- out_cnt  output  4*CNT_W  channel i delivered-beat count at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset: asserting rst_n low immediately clears all four holding registers and all counters.
  - out_valid=0, out_data=0, out_cnt=0.
  - in_ready is then 1, because it is a combinational function of empty slots.
- Reset asserted mid-operation discards held beats with no handshake. The first accept is possible on the first rising edge after deassertion.
- Per-channel "can take": can_take[i] = ~out_valid[i] | out_ready[i]. A full slot being drained in the same cycle can be refilled.
- Ready rule:
  - Unicast (in_bcast=0): in_ready = can_take[in_sel].
  - Broadcast (in_bcast=1): in_ready = AND of can_take[3:0].
  - in_ready must not depend on in_valid.
- Accept: when in_valid & in_ready at edge T, the targeted slot(s) load in_data and out_valid is set from T+1. Latency is exactly one cycle; throughput is one beat per cycle per channel.
- Broadcast is atomic: either all four slots load or none. A partial broadcast must never occur.
- Drain: when out_valid[i] & out_ready[i] and the slot is not reloaded, out_valid[i] clears at the next edge. out_data[i] holds its last value; it is not zeroed.
- Simultaneous drain and load on channel i: the slot takes the new beat, out_valid[i] stays 1, and the counter still increments for the drained beat.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] is stable.
- Isolation: a stalled channel blocks only beats addressed to it, plus all broadcasts. The other channels keep flowing.
- Counters: out_cnt[i] increments by 1 on each output handshake of channel i and wraps from 2^CNT_W-1 to 0 with no flag.
- in_sel and in_bcast are sampled only when in_valid=1. They may change freely while in_valid=0.
- No state machine beyond the per-slot full bit; no combinational path from in_data to out_data.

Decomposition:
- Package demux_pkg:
  - NUM_CH=4, SEL_W=2.
  - Localparam helpers for slicing the packed out_data and out_cnt buses.
- Sub-module demux_slot: one holding register, its full bit, the can_take logic and the CNT_W counter.
  - Instantiated four times by a generate loop.
  - The top level holds only the select decode and the ready/broadcast logic.

Test Plan:
- Reset values: hold rst_n=0 and drive in_valid=1 -> out_valid=4'b0000, out_data=0, out_cnt=0, in_ready=1. Release reset, send sel=2, data=4'hA -> out_valid=4'b0100 and ch2 data=4'hA exactly one cycle later.
- Back-to-back streaming: all out_ready=1, sel=1, stream data 1,2,...,10 on consecutive cycles -> in_ready held 1, ch1 presents 1..10 on consecutive cycles, out_cnt[1]=10.
- Stall isolation: out_ready=4'b1110, send sel=0 twice -> the second beat sees in_ready=0. Then send sel=3, data=4'h5 -> accepted at once, and ch0 still holds the first beat unchanged.
- Atomic broadcast: ch2 full with out_ready[2]=0, send in_bcast=1, data=4'hC -> in_ready=0 and no slot loads. Raise out_ready[2] -> all four slots show 4'hC one cycle after accept.
- Counter wrap and simultaneous drain/load: push 256 beats through ch3 with out_ready[3]=1 -> out_cnt[3] returns to 0, and out_valid[3] never drops while input is continuous.
- Mid-operation reset: slots 0 and 2 full, pulse rst_n low between edges -> out_valid=0 immediately and counters=0. No stale beat appears after release.
